counter_stream_checker: RTL and testbench
=========================================

Name: counter_stream_checker

Overview:
- Receiving-end monitor for the free-running up-counter: samples the counter's q output on a single clock and checks that every valid sample equals the previous sample + 1, wrapping modulo 2^WIDTH.
- Acquires lock after a run of consecutive correct samples, then counts good and bad samples and keeps sticky error information.
- Instantiated in benches and on-fabric self-test, one checker per counter clock domain.

Parameters:
- WIDTH, 8, width of observed counter value q.
- LOCK_THRESH, 4, consecutive correct samples (including the acquiring sample) required to assert locked; legal range 2..255.
- CNT_W, 16, width of good_count and err_count; both saturate.
- CHECK_RST_VAL, 1, when 1 the first valid sample after reset must equal RST_VAL.
- RST_VAL, 0, expected first counter value after reset.

Ports:
- clk  input  1  sampling clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- q_valid  input  1  qualifies q this cycle; sample ignored when 0.
- q  input  WIDTH  observed counter value.
- locked  output  1  checker is in TRACK state.
- err  output  1  sticky; set on first detected error, cleared only by rst.
- err_count  output  CNT_W  number of detected errors, saturating at 2^CNT_W-1.
- good_count  output  CNT_W  correct samples seen while locked, saturating.
- first_bad  output  WIDTH  q value of the first detected error; holds thereafter.
- expected  output  WIDTH  value the next valid sample must carry.

Behaviour:
- Reset: a rst high at a clock edge forces state IDLE. All outputs are 0 from the next cycle: locked, err, err_count, good_count, first_bad, expected. The run counter is also cleared. rst has priority over q_valid in the same cycle. rst asserted mid-run discards all history.
- Timing: all outputs are registered and reflect a sample 1 cycle after the edge at which q_valid=1. With q_valid=0, no state changes.
- IDLE, on first valid sample:
  - If CHECK_RST_VAL=1 and q!=RST_VAL: record an error (see error rules).
  - In all cases: expected<=q+1 (mod 2^WIDTH), run<=1, go to LOCKING.
- LOCKING, on valid sample:
  - Match (q==expected): run<=run+1 and expected<=q+1. If run+1==LOCK_THRESH, go to TRACK and set locked<=1.
  - Mismatch: run<=1 and expected<=q+1 (re-acquire). No error is recorded; mismatches while unlocked are not counted.
- TRACK, on valid sample:
  - Match: good_count increments (saturating) and expected<=q+1.
  - Mismatch: record an error, locked<=0, run<=1, expected<=q+1, go to LOCKING.
- Error recording:
  - err_count increments (saturating).
  - If err was 0: first_bad<=q and err<=1.
  - err and first_bad never change again until rst.
- Wrap-around: expected after q=2^WIDTH-1 is 0. A transition from 255 to 0 (WIDTH=8) is a match, not an error.
- Saturation: at 2^CNT_W-1 the counters hold; no wrap, no flag.
- Stalls: q_valid gaps of any length are transparent. The comparison uses the last valid sample, not the clock count.
- Repeated value (q==previous q) is a mismatch.

Test Plan:
- Reset release, then q=0,1,2,...,9 with q_valid=1 every cycle -> locked rises 1 cycle after the edge sampling q=3; err=0, err_count=0; good_count=6 after q=9.
- Locked stream, then inject q=7 where 5 is expected -> 1 cycle later err=1, err_count=1, first_bad=7, locked=0, expected=8; q=8,9,10 -> locked=1 again after sampling 10. A second bad sample, q=50 where 12 is expected, gives err_count=2 and first_bad stays 7.
- Wrap: locked stream ...,253,254,255,0,1 -> no error, good_count advances through the wrap, expected=2.
- CHECK_RST_VAL=1, first sample after reset q=5 -> err=1, err_count=1, first_bad=5. Then 6,7,8 -> locked. Repeat with CHECK_RST_VAL=0: err stays 0.
- Stall and reset: q_valid toggled 1,0,0,1 with q=0,x,x,1 -> treated as consecutive. Assert rst for 1 cycle while locked with err=1 -> next cycle all outputs 0 and state IDLE. rst and q_valid high in the same cycle -> sample ignored.
- Saturation with CNT_W=4: 20 correct locked samples -> good_count holds at 15. 20 alternating errors -> err_count holds at 15.

Source files
------------

// File: rtl/counter_stream_checker.sv
// counter_stream_checker: receiving-end monitor for a free-running up-counter.
// Each valid sample must equal the previous valid sample + 1 (mod 2^WIDTH).
// Lock is acquired after LOCK_THRESH consecutive correct samples. Once locked,
// the checker counts good and bad samples and keeps sticky first-error data.
module counter_stream_checker #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned LOCK_THRESH   = 4,
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned CHECK_RST_VAL = 1,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             q_valid,
   input  logic [WIDTH-1:0] q,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] good_count,
   output logic [WIDTH-1:0] first_bad,
   output logic [WIDTH-1:0] expected
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCKING = 2'd1,
      TRACK   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [7:0]       THRESH  = 8'(LOCK_THRESH);

   state_t           state_q, state_d;
   logic [7:0]       run_q, run_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [CNT_W-1:0] good_count_q, good_count_d;
   logic [WIDTH-1:0] first_bad_q, first_bad_d;
   logic [WIDTH-1:0] expected_q, expected_d;
   logic             match;
   logic             rec_err;

   assign match = (q == expected_q);

   // Next-state: acquire/track transitions, then shared error recording
   always_comb begin
      state_d      = state_q;
      run_d        = run_q;
      err_d        = err_q;
      err_count_d  = err_count_q;
      good_count_d = good_count_q;
      first_bad_d  = first_bad_q;
      expected_d   = expected_q;
      rec_err      = 1'b0;

      if (q_valid) begin
         // Every valid sample re-seeds the expectation, match or not.
         expected_d = q + WIDTH'(1);
         case (state_q)
            IDLE: begin
               if ((CHECK_RST_VAL != 0) && (q != RST_VAL)) rec_err = 1'b1;
               run_d   = 8'd1;
               state_d = LOCKING;
            end
            LOCKING: begin
               if (match) begin
                  run_d = run_q + 8'd1;
                  if (run_q + 8'd1 == THRESH) state_d = TRACK;
               end else begin
                  // Unlocked mismatches simply restart acquisition.
                  run_d = 8'd1;
               end
            end
            TRACK: begin
               if (match) begin
                  if (good_count_q != CNT_MAX) good_count_d = good_count_q + CNT_W'(1);
               end else begin
                  rec_err = 1'b1;
                  run_d   = 8'd1;
                  state_d = LOCKING;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (rec_err) begin
         if (err_count_q != CNT_MAX) err_count_d = err_count_q + CNT_W'(1);
         if (!err_q) begin
            err_d       = 1'b1;
            first_bad_d = q;
         end
      end
   end

   // State register; synchronous reset discards all history
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         run_q        <= '0;
         err_q        <= 1'b0;
         err_count_q  <= '0;
         good_count_q <= '0;
         first_bad_q  <= '0;
         expected_q   <= '0;
      end else begin
         state_q      <= state_d;
         run_q        <= run_d;
         err_q        <= err_d;
         err_count_q  <= err_count_d;
         good_count_q <= good_count_d;
         first_bad_q  <= first_bad_d;
         expected_q   <= expected_d;
      end
   end

   assign locked     = (state_q == TRACK);
   assign err        = err_q;
   assign err_count  = err_count_q;
   assign good_count = good_count_q;
   assign first_bad  = first_bad_q;
   assign expected   = expected_q;

endmodule

// File: tb/tb_counter_stream_checker.sv
// Scoreboard bench for counter_stream_checker. Three instances share one
// input stream: default parameters, CHECK_RST_VAL=0, and CNT_W=4.
module tb_counter_stream_checker;

   localparam int THRESH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       q_valid = 1'b0;
   logic [7:0] q = '0;

   logic       lk_a, er_a, lk_b, er_b, lk_c, er_c;
   logic [15:0] ec_a, gc_a, ec_b, gc_b;
   logic [3:0]  ec_c, gc_c;
   logic [7:0]  fb_a, ex_a, fb_b, ex_b, fb_c, ex_c;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   counter_stream_checker #(.WIDTH(8), .LOCK_THRESH(THRESH), .CNT_W(16), .CHECK_RST_VAL(1), .RST_VAL(8'd0)) u_a (
      .clk(clk), .rst(rst), .q_valid(q_valid), .q(q),
      .locked(lk_a), .err(er_a), .err_count(ec_a), .good_count(gc_a), .first_bad(fb_a), .expected(ex_a));

   counter_stream_checker #(.WIDTH(8), .LOCK_THRESH(THRESH), .CNT_W(16), .CHECK_RST_VAL(0), .RST_VAL(8'd0)) u_b (
      .clk(clk), .rst(rst), .q_valid(q_valid), .q(q),
      .locked(lk_b), .err(er_b), .err_count(ec_b), .good_count(gc_b), .first_bad(fb_b), .expected(ex_b));

   counter_stream_checker #(.WIDTH(8), .LOCK_THRESH(THRESH), .CNT_W(4), .CHECK_RST_VAL(1), .RST_VAL(8'd0)) u_c (
      .clk(clk), .rst(rst), .q_valid(q_valid), .q(q),
      .locked(lk_c), .err(er_c), .err_count(ec_c), .good_count(gc_c), .first_bad(fb_c), .expected(ex_c));

   // Reference model: remembers the last valid value and how long the
   // current unbroken +1 streak is; counters saturate at cmax.
   typedef struct {
      bit has_prev;
      int last;
      int streak;
      bit locked;
      bit err;
      int errc;
      int good;
      int fb;
   } mdl_t;

   mdl_t ma, mb, mc;
   mdl_t qa[$], qb[$], qc[$];

   function automatic mdl_t mdl_reset();
      mdl_t m;
      m = '{has_prev: 0, last: 0, streak: 0, locked: 0, err: 0, errc: 0, good: 0, fb: 0};
      return m;
   endfunction

   function automatic mdl_t mdl_err(mdl_t m, int qv, int cmax);
      if (m.errc < cmax) m.errc++;
      if (!m.err) begin m.err = 1; m.fb = qv; end
      return m;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, bit v, int qv, bit chk, int cmax);
      bit ok;
      if (!v) return m;
      if (!m.has_prev) begin
         if (chk && qv != 0) m = mdl_err(m, qv, cmax);
         m.streak = 1;
      end else begin
         ok = (qv == (m.last + 1) % 256);
         if (m.locked) begin
            if (ok) begin
               if (m.good < cmax) m.good++;
            end else begin
               m = mdl_err(m, qv, cmax);
               m.locked = 0;
               m.streak = 1;
            end
         end else if (ok) begin
            m.streak++;
            if (m.streak >= THRESH) m.locked = 1;
         end else begin
            m.streak = 1;
         end
      end
      m.has_prev = 1;
      m.last = qv;
      return m;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input int req);
      total++;
      if (act !== 32'(req)) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic cmp_all(input string tag, input mdl_t m, input logic lk, input logic er,
                          input logic [15:0] ec, input logic [15:0] gc,
                          input logic [7:0] fb, input logic [7:0] ex);
      cmp({tag, ".locked"},     32'(lk), int'(m.locked));
      cmp({tag, ".err"},        32'(er), int'(m.err));
      cmp({tag, ".err_count"},  32'(ec), m.errc);
      cmp({tag, ".good_count"}, 32'(gc), m.good);
      cmp({tag, ".first_bad"},  32'(fb), m.fb);
      cmp({tag, ".expected"},   32'(ex), m.has_prev ? (m.last + 1) % 256 : 0);
   endtask

   // Monitor: outputs are registered, so each edge's expectation is checked just after it
   initial forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
         cmp_all("a", qa.pop_front(), lk_a, er_a, ec_a, gc_a, fb_a, ex_a);
         cmp_all("b", qb.pop_front(), lk_b, er_b, ec_b, gc_b, fb_b, ex_b);
         cmp_all("c", qc.pop_front(), lk_c, er_c, 16'(ec_c), 16'(gc_c), fb_c, ex_c);
      end
   end

   int lastq = 0;

   // Drive one cycle of stimulus and push what each instance should show after the edge
   task automatic step(input bit r, input bit v, input int qv);
      @(negedge clk);
      rst = r; q_valid = v; q = 8'(qv);
      if (r) begin
         ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset();
      end else begin
         ma = mdl_step(ma, v, qv, 1'b1, 65535);
         mb = mdl_step(mb, v, qv, 1'b0, 65535);
         mc = mdl_step(mc, v, qv, 1'b1, 15);
         if (v) lastq = qv;
      end
      qa.push_back(ma); qb.push_back(mb); qc.push_back(mc);
   endtask

   task automatic send(input int qv);
      step(1'b0, 1'b1, qv);
   endtask

   initial begin
      ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset();

      // Reset state, then clean count 0..9
      step(1, 0, 0); step(1, 0, 0);
      for (int i = 0; i <= 9; i++) send(i);

      // Error injection while locked, relock, second error
      step(1, 0, 0);
      for (int i = 0; i <= 4; i++) send(i);
      send(7); send(8); send(9); send(10); send(11); send(50);

      // Wrap-around while locked
      step(1, 0, 0);
      send(0);
      for (int i = 251; i <= 255; i++) send(i);
      send(0); send(1); send(2);

      // Wrong first value after reset, then relock
      step(1, 0, 0);
      send(5); send(6); send(7); send(8); send(9);

      // Stalls are transparent; repeated value is a mismatch
      step(1, 0, 0);
      send(0);
      step(0, 0, $urandom_range(0, 255));
      step(0, 0, $urandom_range(0, 255));
      send(1); send(2); send(3); send(4); send(4); send(5);

      // Reset while locked with err set; reset with q_valid high
      step(1, 0, 0);
      send(9);
      for (int i = 0; i <= 5; i++) send(i);
      send(40);
      step(1, 1, 41);
      step(1, 1, 0);
      send(0); send(1);

      // Saturation: many good samples, then alternating relock/error rounds
      step(1, 0, 0);
      for (int i = 0; i < 24; i++) send(i);
      for (int r = 0; r < 20; r++) begin
         for (int k = 0; k < THRESH; k++) send((lastq + 1) % 256);
         send((lastq + 2 + $urandom_range(0, 200)) % 256);
      end

      // Random stream with gaps, mostly in sequence
      step(1, 0, 0);
      for (int i = 0; i < 400; i++) begin
         int pick;
         pick = $urandom_range(0, 99);
         if (pick < 15)      step(0, 0, $urandom_range(0, 255));
         else if (pick < 22) send($urandom_range(0, 255));
         else if (pick < 25) send(lastq);
         else if (pick < 26) step(1, $urandom_range(0, 1), $urandom_range(0, 255));
         else                send((lastq + 1) % 256);
      end

      step(0, 0, 0);
      repeat (3) @(posedge clk);
      #2;
      total++;
      if (qa.size() != 0) begin
         bad++;
         $display("FAIL drain actual=%0d required=0", qa.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
